// File: rtl/axi_ar_error_responder.sv
// axi_ar_error_responder: answers an unmapped AR with ARLEN+1 DECERR R beats after earlier reads drain.
// Optional macro AXI_ERR_RDATA_PATTERN_EN drives 32'hBADACCE5 on rdata_o instead of zeros.
module axi_ar_error_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  error_req_i,
    input  logic                  sample_ardata_info_i,
    input  logic [ID_WIDTH-1:0]   arid_i,
    input  logic [7:0]            arlen_i,
    input  logic [USER_WIDTH-1:0] aruser_i,
    input  logic                  outstanding_trans_i,
    output logic                  error_gnt_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic [USER_WIDTH-1:0] ruser_o,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, DRAIN, SEND} state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [USER_WIDTH-1:0] user_q, user_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        user_d      = user_q;
        rvalid_o    = 1'b0;
        error_gnt_o = 1'b0;
        case (state_q)
            IDLE: if (sample_ardata_info_i) begin
                state_d = DRAIN;
                id_d    = arid_i;
                user_d  = aruser_i;
                cnt_d   = arlen_i;
            end
            DRAIN: if (!outstanding_trans_i) state_d = SEND;
            SEND: begin
                rvalid_o = 1'b1;
                if (rready_i) begin
                    if (cnt_q == 8'd0) begin
                        error_gnt_o = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            user_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            user_q  <= user_d;
        end
    end

    assign rlast_o = (state_q == SEND) && (cnt_q == 8'd0);
    assign rresp_o = rvalid_o ? 2'b11 : 2'b00;
    assign busy_o  = state_q != IDLE;
    assign rid_o   = id_q;
    assign ruser_o = user_q;

`ifdef AXI_ERR_RDATA_PATTERN_EN
    localparam logic [DATA_WIDTH-1:0] PATTERN = {(DATA_WIDTH/32){32'hBADACCE5}};
    // rdata is constant once any burst has started, so a flag replaces a data register
    logic pat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pat_q <= 1'b0;
        else if (state_q == DRAIN && !outstanding_trans_i) pat_q <= 1'b1;
    end
    assign rdata_o = pat_q ? PATTERN : '0;
`else
    assign rdata_o = '0;
`endif

    a_sample_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        sample_ardata_info_i |-> error_req_i);
endmodule

// File: doc/axi_ar_error_responder.md
# axi_ar_error_responder

Read-response generator for decode errors in the AXI node. When the AR address decoder matches no reachable initiator port, it raises an error request and pulses its sample strobe. This block then captures the offending AR beat's ID, LEN and USER fields. Once all earlier outstanding reads on the target port have drained, it returns ARLEN+1 R beats with RRESP=DECERR and RLAST on the final beat. It asserts the grant back to the decoder on the final handshake. It sits on the target-side R path, in parallel with the R mux from the initiator ports.

## Interface
Parameters:
- ID_WIDTH, 4, ARID/RID width
- DATA_WIDTH, 64, RDATA width; must be a multiple of 32
- USER_WIDTH, 6, ARUSER/RUSER width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- error_req_i  in  1  decoder reports an unmapped AR address (level)
- sample_ardata_info_i  in  1  one-cycle strobe: capture arid_i/arlen_i/aruser_i
- arid_i  in  ID_WIDTH  AR ID of the failing request
- arlen_i  in  8  AR burst length minus one
- aruser_i  in  USER_WIDTH  AR user field
- outstanding_trans_i  in  1  high while earlier reads on this target port are in flight
- error_gnt_o  out  1  final DECERR beat accepted; decoder may leave its error state
- rvalid_o  out  1  R valid
- rready_i  in  1  R ready
- rid_o  out  ID_WIDTH  captured ARID
- rdata_o  out  DATA_WIDTH  response data
- rresp_o  out  2  fixed 2'b11 (DECERR) while rvalid_o is high, else 2'b00
- rlast_o  out  1  final beat of the burst
- ruser_o  out  USER_WIDTH  captured ARUSER
- busy_o  out  1  state is not IDLE

## Operation
- FSM states: IDLE, DRAIN, SEND. Encode in 2 bits.
- IDLE -> DRAIN when sample_ardata_info_i=1.
  - Same edge: id_q<=arid_i, user_q<=aruser_i, cnt_q<=arlen_i.
- DRAIN -> SEND on the first edge where outstanding_trans_i=0. Otherwise stay in DRAIN.
  - R-channel ordering: responses for earlier transactions always precede the DECERR burst.
- SEND behaviour:
  - rvalid_o=1, rresp_o=2'b11, rid_o=id_q, ruser_o=user_q, rlast_o=(cnt_q==0).
  - On each rvalid_o&rready_i with cnt_q!=0: cnt_q decrements by 1.
  - On handshake with cnt_q==0: error_gnt_o=1 in that same cycle (combinational), and the FSM goes to IDLE.
- cnt_q is 8 bits; no wrap. ARLEN=255 gives exactly 256 beats.
- rvalid_o stays high until it is accepted. id/user/data/last must be stable while rvalid_o=1 and rready_i=0.
- sample_ardata_info_i outside IDLE is a protocol violation. It is ignored (captured fields unchanged); the bench flags it with an assertion.
- error_req_i is used only for the assertion that sample_ardata_info_i is never high without error_req_i. No functional dependency.
- Outside SEND: rvalid_o=0, rlast_o=0, rresp_o=0, error_gnt_o=0. rid_o/ruser_o/rdata_o hold their last values.

## Timing
- Reset values: state=IDLE, cnt_q=0, id_q=0, user_q=0.
  - Outputs: rvalid_o=0, rlast_o=0, rresp_o=0, error_gnt_o=0, busy_o=0, rid_o=0, ruser_o=0, rdata_o=0.
- Latency, sample strobe at edge T with outstanding_trans_i=0:
  - DRAIN during T..T+1.
  - rvalid_o first high after edge T+1 (2 cycles after the strobe).
- Burst of N=ARLEN+1 beats with rready_i tied high: N consecutive beats, error_gnt_o high in the N-th beat's cycle.
- Back-to-back errors: a new sample strobe can arrive the cycle after error_gnt_o. It is accepted, since the state is IDLE on that edge.
- Reset asserted mid-burst: all state and outputs clear asynchronously. No partial RLAST is emitted.

## Configuration
- Macro AXI_ERR_RDATA_PATTERN_EN.
  - Defined: rdata_o in SEND is 32'hBADACCE5 replicated DATA_WIDTH/32 times.
  - Undefined: rdata_o is all zeros at all times. The pattern logic is not synthesized.

## Test plan
- ARLEN=0, ID=4'h5, USER=6'h2A, outstanding low, rready high -> one beat: rid=5, ruser=2A, rresp=3, rlast=1, error_gnt_o high in that cycle; rvalid first high 2 cycles after the strobe.
- ARLEN=3, rready toggling 1,0,0,1,1,0,1 -> exactly 4 accepted beats; outputs stable while stalled; rlast only on beat 4; error_gnt_o with beat 4 only.
- outstanding_trans_i high for 5 cycles after the strobe -> rvalid_o stays 0 for those cycles, then first beat 1 cycle after outstanding_trans_i falls.
- ARLEN=255 -> exactly 256 beats, single rlast, cnt_q never wraps.
- Reset pulse during beat 2 of a 4-beat burst -> rvalid_o/rlast_o/error_gnt_o drop immediately; after release, busy_o=0 and a new ARLEN=1 error completes normally.
- Build with and without AXI_ERR_RDATA_PATTERN_EN, DATA_WIDTH=64 -> rdata_o=64'hBADACCE5BADACCE5 or 64'h0 respectively on every beat.
